lynx_mem_arbiter: RTL and testbench

Shares one single-port synchronous system RAM between three requesters of the Lynx 48 core: the HPS ioctl loader (ROM/tape image download), the CRTC video fetch, and the Z80 CPU bus. It drives the RAM port from registered outputs, returns read data with a fixed pipeline latency, and applies back-pressure to the loader via `ioctl_wait`. Priority is fixed (loader > video > CPU), with a bounded-starvation rule that guarantees the CPU a slot.

---
 rtl/lynx_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_lynx_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lynx_mem_arbiter.sv
// lynx_mem_arbiter: shares one single-port synchronous RAM between the HPS
// ioctl loader, the CRTC video fetch and the Z80 CPU. Fixed priority
// loader > video > CPU, with a video-run limit that lets a waiting CPU in.
// The RAM port is driven from registers; reads return after two edges,
// CPU writes acknowledge after one.
module lynx_mem_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int VID_RUN_MAX = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    // HPS ioctl loader
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [DW-1:0] ioctl_dout,
    output logic          ioctl_wait,
    // CRTC video fetch
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_data,
    // Z80 CPU bus
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    // RAM port
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LDR  = 2'd1,
        GNT_VID  = 2'd2,
        GNT_CPU  = 2'd3
    } gnt_e;

    localparam logic [1:0] RUN_MAX = 2'(VID_RUN_MAX);

    // Loader holding register
    logic          hold_full_q;
    logic [AW-1:0] hold_addr_q;
    logic [DW-1:0] hold_data_q;

    // Per-requester "transaction in flight" flags and the video run counter
    logic          vid_out_q;
    logic          cpu_out_q;
    logic [1:0]    vid_run_q;
    logic [1:0]    vid_run_d;

    // Access pipeline: stage 1 = RAM port presented, stage 2 = read data on ram_dout
    gnt_e          s1_src_q;
    logic          s1_we_q;
    gnt_e          s2_src_q;

    // Registered outputs
    logic [AW-1:0] ram_addr_q;
    logic          ram_we_q;
    logic [DW-1:0] ram_din_q;
    logic          vid_ack_q;
    logic [DW-1:0] vid_data_q;
    logic          cpu_ack_q;
    logic [DW-1:0] cpu_dout_q;

    logic          vid_elig;
    logic          cpu_elig;
    gnt_e          gnt_d;
    logic          vid_ack_d;
    logic          cpu_ack_d;

    // Eligibility, winner selection and next video-run count
    always_comb begin
        // An ack presented this cycle means the requester still shows the old req
        vid_elig  = vid_req && !vid_out_q && !vid_ack_q;
        cpu_elig  = cpu_req && !cpu_out_q && !cpu_ack_q && !ioctl_download;

        gnt_d = GNT_NONE;
        if (hold_full_q)
            gnt_d = GNT_LDR;
        else if (cpu_elig && vid_elig && (vid_run_q == RUN_MAX))
            gnt_d = GNT_CPU;
        else if (vid_elig)
            gnt_d = GNT_VID;
        else if (cpu_elig)
            gnt_d = GNT_CPU;

        vid_run_d = vid_run_q;
        if (gnt_d == GNT_CPU || !cpu_elig)
            vid_run_d = 2'd0;
        else if (gnt_d == GNT_VID && vid_run_q != RUN_MAX)
            vid_run_d = vid_run_q + 2'd1;

        vid_ack_d = (s2_src_q == GNT_VID);
        cpu_ack_d = (s2_src_q == GNT_CPU) || (s1_src_q == GNT_CPU && s1_we_q);
    end

    // Loader holding register: capture when empty, drain on loader grant
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else if (!hold_full_q) begin
            if (ioctl_wr) begin
                hold_full_q <= 1'b1;
                hold_addr_q <= ioctl_addr;
                hold_data_q <= ioctl_dout;
            end
        end else if (gnt_d == GNT_LDR) begin
            hold_full_q <= 1'b0;
        end
    end

    // Drive the RAM port from the winner; idle keeps the address, drops we
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
        end else begin
            unique case (gnt_d)
                GNT_LDR: begin
                    ram_addr_q <= hold_addr_q;
                    ram_we_q   <= 1'b1;
                    ram_din_q  <= hold_data_q;
                end
                GNT_VID: begin
                    ram_addr_q <= vid_addr;
                    ram_we_q   <= 1'b0;
                end
                GNT_CPU: begin
                    ram_addr_q <= cpu_addr;
                    ram_we_q   <= cpu_we;
                    if (cpu_we)
                        ram_din_q <= cpu_din;
                end
                default: begin
                    ram_we_q   <= 1'b0;
                end
            endcase
        end
    end

    // Track accesses through the RAM latency and return data with the ack
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            s1_src_q   <= GNT_NONE;
            s1_we_q    <= 1'b0;
            s2_src_q   <= GNT_NONE;
            vid_ack_q  <= 1'b0;
            vid_data_q <= '0;
            cpu_ack_q  <= 1'b0;
            cpu_dout_q <= '0;
        end else begin
            // Loader writes need no response, so they never enter the pipeline
            s1_src_q  <= (gnt_d == GNT_VID || gnt_d == GNT_CPU) ? gnt_d : GNT_NONE;
            s1_we_q   <= (gnt_d == GNT_CPU) && cpu_we;
            s2_src_q  <= (s1_src_q != GNT_NONE && !s1_we_q) ? s1_src_q : GNT_NONE;
            vid_ack_q <= vid_ack_d;
            cpu_ack_q <= cpu_ack_d;
            if (s2_src_q == GNT_VID)
                vid_data_q <= ram_dout;
            if (s2_src_q == GNT_CPU)
                cpu_dout_q <= ram_dout;
        end
    end

    // Outstanding flags (set on grant, cleared when the ack is issued) and run count
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vid_out_q <= 1'b0;
            cpu_out_q <= 1'b0;
            vid_run_q <= 2'd0;
        end else begin
            vid_run_q <= vid_run_d;
            if (gnt_d == GNT_VID)
                vid_out_q <= 1'b1;
            else if (vid_ack_d)
                vid_out_q <= 1'b0;
            if (gnt_d == GNT_CPU)
                cpu_out_q <= 1'b1;
            else if (cpu_ack_d)
                cpu_out_q <= 1'b0;
        end
    end

    assign ioctl_wait = hold_full_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_din    = ram_din_q;
    assign vid_ack    = vid_ack_q;
    assign vid_data   = vid_data_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_dout   = cpu_dout_q;

endmodule

// File: tb/tb_lynx_mem_arbiter.sv
// Testbench for lynx_mem_arbiter: a behavioural RAM, a table of CPU
// transactions, directed multi-cycle sequences and a randomized run
// checked against a rule-level model of the arbiter.
module tb_lynx_mem_arbiter;
    localparam int RUNMAX = 3;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        vid_req, vid_ack;
    logic [15:0] vid_addr;
    logic [7:0]  vid_data;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din, ram_dout;

    int n_vec  = 0;
    int n_miss = 0;

    lynx_mem_arbiter #(.AW(16), .DW(8), .VID_RUN_MAX(RUNMAX)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Single-port synchronous RAM, registered read, filled with init_val once
    logic [7:0] mem [0:65535];
    logic       mem_fill;
    always @(posedge clk_sys) begin
        if (mem_fill) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
        chk({tag, "_ram_we"}, 32'(ram_we), 0);
        chk({tag, "_ram_din"}, 32'(ram_din), 0);
        chk({tag, "_vid_ack"}, 32'(vid_ack), 0);
        chk({tag, "_vid_data"}, 32'(vid_data), 0);
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
        chk({tag, "_cpu_dout"}, 32'(cpu_dout), 0);
        chk({tag, "_ioctl_wait"}, 32'(ioctl_wait), 0);
    endtask

    // One CPU transaction from idle: grant on the first edge, then count edges to ack
    task automatic cpu_txn(input logic we, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] exp, input int exp_lat, input string tag);
        int lat;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        tick();
        chk({tag, "_grant_addr"}, 32'(ram_addr), 32'(a));
        chk({tag, "_grant_we"}, 32'(ram_we), 32'(we));
        if (we) chk({tag, "_grant_din"}, 32'(ram_din), 32'(d));
        lat = 0;
        while (cpu_ack !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_ack_latency"}, 32'(lat), 32'(exp_lat));
        if (!we) chk({tag, "_cpu_dout"}, 32'(cpu_dout), 32'(exp));
        $display("cpu %s addr=%04h din=%02h dout=%02h latency=%0d", we ? "wr" : "rd", a, d, cpu_dout, lat);
        cpu_req = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp;
        int          lat;
    } cvec_t;
    cvec_t tbl [8];

    // Reference-model state for the randomized run
    logic [7:0]  shadow [0:65535];
    bit          m_hold_full;
    logic [15:0] m_hold_addr, last_addr;
    logic [7:0]  m_hold_data, vid_exp, cpu_exp;
    int          m_vid_free, m_cpu_free, m_run, vid_due, cpu_due, win;
    bit          vel, cel, have_last, e_we;
    logic [3:0]  r4;

    initial begin
        tbl[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 1};
        tbl[1] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 2};
        tbl[2] = '{1'b1, 16'hFFFF, 8'h3C, 8'h00, 1};
        tbl[3] = '{1'b1, 16'h0000, 8'hC3, 8'h00, 1};
        tbl[4] = '{1'b0, 16'hFFFF, 8'h00, 8'h3C, 2};
        tbl[5] = '{1'b0, 16'h0000, 8'h00, 8'hC3, 2};
        tbl[6] = '{1'b0, 16'h0ABC, 8'h00, 8'hB6, 2};
        tbl[7] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 2};

        reset = 1'b1; mem_fill = 1'b1;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        tick();
        mem_fill = 1'b0;
        tick();
        tick();
        check_all_zero("rst_init");
        reset = 1'b0;

        // Table of CPU transactions
        for (int i = 0; i < 8; i++)
            cpu_txn(tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].exp, tbl[i].lat, $sformatf("tbl%0d", i));

        // Video and CPU read on the same edge: video first, acks on consecutive cycles
        vid_req = 1'b1; vid_addr = 16'h4000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4001;
        tick();
        chk("sim_first_addr", 32'(ram_addr), 32'h4000);
        tick();
        chk("sim_second_addr", 32'(ram_addr), 32'h4001);
        chk("sim_vid_ack_early", 32'(vid_ack), 0);
        tick();
        chk("sim_vid_ack", 32'(vid_ack), 1);
        chk("sim_vid_data", 32'(vid_data), 32'h40);
        chk("sim_cpu_ack_early", 32'(cpu_ack), 0);
        vid_req = 1'b0;
        tick();
        chk("sim_cpu_ack", 32'(cpu_ack), 1);
        chk("sim_cpu_dout", 32'(cpu_dout), 32'h41);
        chk("sim_vid_ack_once", 32'(vid_ack), 0);
        cpu_req = 1'b0;
        tick();

        // Continuous video plus held CPU: the CPU is never starved past the run limit
        begin
            int run, maxrun, nc;
            run = 0; maxrun = 0; nc = 0;
            vid_req = 1'b1; vid_addr = 16'h5000;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5001;
            for (int i = 0; i < 48; i++) begin
                tick();
                if (vid_ack) begin run++; if (run > maxrun) maxrun = run; end
                if (cpu_ack) begin nc++; run = 0; end
            end
            vid_req = 1'b0; cpu_req = 1'b0;
            chk("vc_max_video_run_ok", 32'(maxrun <= RUNMAX), 1);
            chk("vc_cpu_served_ok", 32'(nc >= 8), 1);
            repeat (4) tick();
        end

        // CPU blocked during download, granted on the first edge after it falls
        begin
            int seen;
            seen = 0;
            ioctl_download = 1'b1;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2345;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (cpu_ack || ram_addr == 16'h2345) seen++;
            end
            chk("dl_cpu_blocked", 32'(seen), 0);
            ioctl_download = 1'b0;
            tick();
            chk("dl_grant_after_fall", 32'(ram_addr), 32'h2345);
            tick();
            tick();
            chk("dl_cpu_ack", 32'(cpu_ack), 1);
            chk("dl_cpu_dout", 32'(cpu_dout), 32'h66);
            cpu_req = 1'b0;
            tick();
        end

        // Loader burst: one write every two cycles, wait high exactly one cycle each
        ioctl_download = 1'b1;
        for (int a = 0; a < 256; a++) begin
            ioctl_wr = 1'b1; ioctl_addr = 16'(a); ioctl_dout = 8'(a);
            tick();
            chk($sformatf("ldr%0d_wait_set", a), 32'(ioctl_wait), 1);
            if (a == 8'h80) begin
                // Strobe while full must neither capture nor disturb the held entry
                ioctl_addr = 16'hBEEF; ioctl_dout = 8'hEE;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
            chk($sformatf("ldr%0d_wait_clr", a), 32'(ioctl_wait), 0);
            chk($sformatf("ldr%0d_ram_we", a), 32'(ram_we), 1);
            chk($sformatf("ldr%0d_ram_addr", a), 32'(ram_addr), 32'(a));
            chk($sformatf("ldr%0d_ram_din", a), 32'(ram_din), 32'(a));
            if (a == 8'h80) begin
                ioctl_wr = 1'b0;
                tick();
                chk("ldr_full_ignore_wait", 32'(ioctl_wait), 0);
                chk("ldr_full_ignore_we", 32'(ram_we), 0);
            end
        end
        ioctl_download = 1'b0;
        cpu_txn(1'b0, 16'h0042, 8'h00, 8'h42, 2, "ldr_readback");
        cpu_txn(1'b0, 16'hBEEF, 8'h00, 8'h51, 2, "ldr_no_stray");

        // Asynchronous reset with a video read in flight and the hold full
        vid_req = 1'b1; vid_addr = 16'h4001;
        ioctl_wr = 1'b1; ioctl_addr = 16'h3000; ioctl_dout = 8'h77;
        tick();
        chk("rst_pre_grant", 32'(ram_addr), 32'h4001);
        chk("rst_pre_wait", 32'(ioctl_wait), 1);
        ioctl_wr = 1'b0; vid_req = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_hold%0d_vid_ack", i), 32'(vid_ack), 0);
        end
        reset = 1'b0;
        vid_req = 1'b1; vid_addr = 16'h4001;
        tick();
        chk("rst_first_grant", 32'(ram_addr), 32'h4001);
        tick();
        chk("rst_vid_ack_early", 32'(vid_ack), 0);
        tick();
        chk("rst_vid_ack", 32'(vid_ack), 1);
        chk("rst_vid_data", 32'(vid_data), 32'h41);
        vid_req = 1'b0;
        tick();
        cpu_txn(1'b0, 16'h3000, 8'h00, 8'h30, 2, "rst_hold_dropped");

        // Randomized run against the rule-level model
        repeat (4) tick();
        for (int i = 0; i < 65536; i++) shadow[i] = mem[i];
        m_hold_full = 1'b0; m_hold_addr = '0; m_hold_data = '0;
        m_vid_free = 0; m_cpu_free = 0; m_run = 0; vid_due = -1; cpu_due = -1;
        have_last = 1'b0; last_addr = '0; vid_exp = '0; cpu_exp = '0;
        for (int k = 0; k < 3000; k++) begin
            vel = vid_req && (k >= m_vid_free);
            cel = cpu_req && (k >= m_cpu_free) && !ioctl_download;
            if (m_hold_full)                      win = 1;
            else if (cel && vel && m_run == RUNMAX) win = 3;
            else if (vel)                         win = 2;
            else if (cel)                         win = 3;
            else                                  win = 0;
            if (win == 3 || !cel) m_run = 0;
            else if (win == 2 && m_run < RUNMAX) m_run++;
            e_we = 1'b0;
            if (win == 1) begin
                shadow[m_hold_addr] = m_hold_data;
                m_hold_full = 1'b0;
                e_we = 1'b1;
                last_addr = m_hold_addr;
            end else if (ioctl_wr) begin
                m_hold_full = 1'b1; m_hold_addr = ioctl_addr; m_hold_data = ioctl_dout;
            end
            if (win == 2) begin
                m_vid_free = k + 4; vid_due = k + 2; vid_exp = shadow[vid_addr];
                last_addr = vid_addr;
            end
            if (win == 3) begin
                last_addr = cpu_addr;
                if (cpu_we) begin
                    shadow[cpu_addr] = cpu_din; cpu_due = k + 1; m_cpu_free = k + 3; e_we = 1'b1;
                end else begin
                    cpu_exp = shadow[cpu_addr]; cpu_due = k + 2; m_cpu_free = k + 4;
                end
            end
            if (win != 0) have_last = 1'b1;

            tick();
            chk($sformatf("rnd%0d_ram_we", k), 32'(ram_we), 32'(e_we));
            if (have_last) chk($sformatf("rnd%0d_ram_addr", k), 32'(ram_addr), 32'(last_addr));
            if (e_we) chk($sformatf("rnd%0d_ram_din", k), 32'(ram_din), 32'(win == 1 ? shadow[last_addr] : cpu_din));
            chk($sformatf("rnd%0d_vid_ack", k), 32'(vid_ack), 32'(k == vid_due));
            if (k == vid_due) chk($sformatf("rnd%0d_vid_data", k), 32'(vid_data), 32'(vid_exp));
            chk($sformatf("rnd%0d_cpu_ack", k), 32'(cpu_ack), 32'(k == cpu_due));
            if (k == cpu_due && cpu_due == m_cpu_free - 4 + 2) chk($sformatf("rnd%0d_cpu_dout", k), 32'(cpu_dout), 32'(cpu_exp));
            chk($sformatf("rnd%0d_ioctl_wait", k), 32'(ioctl_wait), 32'(m_hold_full));

            // Next stimulus: requesters follow the handshake as the model predicts it
            if (vid_req) begin
                if (k == vid_due) begin
                    if ($urandom_range(3) == 0) begin r4 = 4'($urandom_range(15)); vid_addr = {12'h7F0, r4}; end
                    else vid_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                vid_req = 1'b1; r4 = 4'($urandom_range(15)); vid_addr = {12'h7F0, r4};
            end
            if (cpu_req) begin
                if (k == cpu_due) begin
                    if ($urandom_range(3) == 0) begin
                        r4 = 4'($urandom_range(15)); cpu_addr = {12'h7F0, r4};
                        cpu_we = 1'($urandom_range(1)); cpu_din = 8'($urandom);
                    end else cpu_req = 1'b0;
                end
            end else if ($urandom_range(1) == 0) begin
                cpu_req = 1'b1; r4 = 4'($urandom_range(15)); cpu_addr = {12'h7F0, r4};
                cpu_we = 1'($urandom_range(1)); cpu_din = 8'($urandom);
            end
            ioctl_wr = ($urandom_range(2) == 0);
            r4 = 4'($urandom_range(15));
            ioctl_addr = {12'h7F0, r4};
            ioctl_dout = 8'($urandom);
            if ($urandom_range(39) == 0) ioctl_download = ~ioctl_download;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
